// File: rtl/operand_stack_pkg.sv
// operand_stack_pkg: command codes, FSM state encodings and sizing helper
// shared by the operand stack, its regfile and anything driving its command port.
package operand_stack_pkg;

   typedef enum logic [2:0] {
      CMD_NOP   = 3'b000,
      CMD_PUSH  = 3'b001,
      CMD_POP   = 3'b010,
      CMD_BINOP = 3'b011,
      CMD_UNOP  = 3'b100,
      CMD_DUP   = 3'b101,
      CMD_SWAP  = 3'b110,
      CMD_CLR   = 3'b111
   } cmd_t;

   localparam logic [0:0] ST_RUN = 1'b0;
   localparam logic [0:0] ST_ERR = 1'b1;

   // Address width for an n-entry memory; never below one bit.
   function automatic int unsigned addr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/operand_stack_if.sv
// operand_stack_if: command/data bus between the stack controller (master)
// and the operand stack (slave). The ALU result travels on this bus too.
interface operand_stack_if #(
   parameter int WIDTH = 16,
   parameter int CW    = 5
);
   logic [2:0]       cmd;
   logic [WIDTH-1:0] push_data;
   logic [WIDTH-1:0] alu_s;
   logic [WIDTH-1:0] tos;
   logic [WIDTH-1:0] nos;
   logic [CW-1:0]    count;
   logic             empty;
   logic             full;
   logic             err;
   logic             err_ovf;

   modport master (
      output cmd, push_data, alu_s,
      input  tos, nos, count, empty, full, err, err_ovf
   );

   modport slave (
      input  cmd, push_data, alu_s,
      output tos, nos, count, empty, full, err, err_ovf
   );
endinterface

// File: rtl/operand_stack_regfile.sv
// stack_regfile: backing store for stack entries below tos/nos.
// One synchronous write port, one asynchronous read port, no reset.
module stack_regfile
   import operand_stack_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 14
) (
   input  logic                               clk,
   input  logic                               we,
   input  logic [addr_width(DEPTH)-1:0]       waddr,
   input  logic [WIDTH-1:0]                   wdata,
   input  logic [addr_width(DEPTH)-1:0]       raddr,
   output logic [WIDTH-1:0]                   rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Spill write from nos when a push deepens the stack.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata = r_mem[raddr];

endmodule

// File: rtl/operand_stack.sv
// operand_stack: 16-bit LIFO feeding the ALU. tos/nos are dedicated
// registers driving ALU a/b; deeper entries spill to stack_regfile.
// Any command whose depth requirement fails traps into a sticky ERR state
// that only CLR or reset leaves.
module operand_stack
   import operand_stack_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   parameter int CW    = 5
) (
   input  logic             clk,
   input  logic             rst,
   operand_stack_if.slave   bus
);

   localparam int unsigned RF_DEPTH = DEPTH - 2;
   localparam int unsigned AW       = addr_width(RF_DEPTH);

   logic [WIDTH-1:0] r_tos, r_nos;
   logic [CW-1:0]    r_count;
   logic [0:0]       r_state;
   logic             r_err_ovf;

   logic [WIDTH-1:0] w_tos_nx, w_nos_nx;
   logic [CW-1:0]    w_cnt_nx;
   logic [0:0]       w_state_nx;
   logic             w_ovf_nx;

   cmd_t             w_cmd;
   logic             w_empty, w_full, w_ge2, w_ge3;
   logic             w_we;
   logic [AW-1:0]    w_waddr, w_raddr;
   logic [WIDTH-1:0] w_rdata, w_refill;

   assign w_cmd   = cmd_t'(bus.cmd);
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));
   assign w_ge2   = (r_count >= CW'(2));
   assign w_ge3   = (r_count >= CW'(3));

   // Entry index i holds stack position count-1-i, so the slot just under
   // nos is count-3 and the slot nos spills into on a push is count-2.
   assign w_waddr  = AW'(r_count - CW'(2));
   assign w_raddr  = AW'(r_count - CW'(3));
   assign w_refill = w_ge3 ? w_rdata : '0;

   stack_regfile #(
      .WIDTH (WIDTH),
      .DEPTH (RF_DEPTH)
   ) u_regfile (
      .clk   (clk),
      .we    (w_we),
      .waddr (w_waddr),
      .wdata (r_nos),
      .raddr (w_raddr),
      .rdata (w_rdata)
   );

   // Decode the command against the current depth and FSM state.
   always_comb begin
      w_tos_nx   = r_tos;
      w_nos_nx   = r_nos;
      w_cnt_nx   = r_count;
      w_state_nx = r_state;
      w_ovf_nx   = r_err_ovf;
      w_we       = 1'b0;

      if (w_cmd == CMD_CLR) begin
         w_tos_nx   = '0;
         w_nos_nx   = '0;
         w_cnt_nx   = '0;
         w_state_nx = ST_RUN;
         w_ovf_nx   = 1'b0;
      end else if (r_state == ST_RUN) begin
         case (w_cmd)
            CMD_PUSH, CMD_DUP: begin
               if (w_full) begin
                  w_state_nx = ST_ERR;
                  w_ovf_nx   = 1'b1;
               end else if ((w_cmd == CMD_DUP) && w_empty) begin
                  w_state_nx = ST_ERR;
                  w_ovf_nx   = 1'b0;
               end else begin
                  w_we     = w_ge2;
                  w_nos_nx = r_tos;
                  w_tos_nx = (w_cmd == CMD_DUP) ? r_tos : bus.push_data;
                  w_cnt_nx = r_count + CW'(1);
               end
            end
            CMD_POP: begin
               if (w_empty) begin
                  w_state_nx = ST_ERR;
                  w_ovf_nx   = 1'b0;
               end else begin
                  w_tos_nx = r_nos;
                  w_nos_nx = w_refill;
                  w_cnt_nx = r_count - CW'(1);
               end
            end
            CMD_BINOP: begin
               if (!w_ge2) begin
                  w_state_nx = ST_ERR;
                  w_ovf_nx   = 1'b0;
               end else begin
                  w_tos_nx = bus.alu_s;
                  w_nos_nx = w_refill;
                  w_cnt_nx = r_count - CW'(1);
               end
            end
            CMD_UNOP: begin
               if (w_empty) begin
                  w_state_nx = ST_ERR;
                  w_ovf_nx   = 1'b0;
               end else begin
                  w_tos_nx = bus.alu_s;
               end
            end
            CMD_SWAP: begin
               if (!w_ge2) begin
                  w_state_nx = ST_ERR;
                  w_ovf_nx   = 1'b0;
               end else begin
                  w_tos_nx = r_nos;
                  w_nos_nx = r_tos;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // State registers; asynchronous reset discards any in-flight command.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tos     <= '0;
         r_nos     <= '0;
         r_count   <= '0;
         r_state   <= ST_RUN;
         r_err_ovf <= 1'b0;
      end else begin
         r_tos     <= w_tos_nx;
         r_nos     <= w_nos_nx;
         r_count   <= w_cnt_nx;
         r_state   <= w_state_nx;
         r_err_ovf <= w_ovf_nx;
      end
   end

   assign bus.tos     = r_tos;
   assign bus.nos     = r_nos;
   assign bus.count   = r_count;
   assign bus.empty   = w_empty;
   assign bus.full    = w_full;
   assign bus.err     = (r_state == ST_ERR);
   assign bus.err_ovf = r_err_ovf;

endmodule

// File: tb/tb_operand_stack.sv
// tb_operand_stack: directed test-plan sequences plus randomized commands,
// checked against a queue-based stack model through a scoreboard.
module tb_operand_stack;
   import operand_stack_pkg::*;

   localparam int WIDTH = 16;
   localparam int DEPTH = 16;
   localparam int CW    = 5;

   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_BNOT = 2;
   localparam int ALU_XOR  = 3;

   logic clk = 1'b0;
   logic rst;
   int   alu_op;

   always #5 clk = ~clk;

   operand_stack_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

   operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ALU model: a = tos (right/unary operand), b = nos (left operand).
   function automatic logic [15:0] alu_fn(input int op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         ALU_ADD:  return b + a;
         ALU_SUB:  return b - a;
         ALU_BNOT: return ~a;
         default:  return b ^ a;
      endcase
   endfunction

   assign bus.alu_s = alu_fn(alu_op, bus.tos, bus.nos);

   typedef struct {
      logic [15:0] tos;
      logic [15:0] nos;
      logic [4:0]  count;
      logic        empty;
      logic        full;
      logic        err;
      logic        ovf;
      string       name;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] m_stk[$];
   bit          m_err;
   bit          m_ovf;
   int          errors = 0;
   int          checks = 0;

   function automatic logic [15:0] m_tos();
      return (m_stk.size() >= 1) ? m_stk[m_stk.size()-1] : 16'h0;
   endfunction

   function automatic logic [15:0] m_nos();
      return (m_stk.size() >= 2) ? m_stk[m_stk.size()-2] : 16'h0;
   endfunction

   function automatic void m_reset();
      m_stk.delete();
      m_err = 1'b0;
      m_ovf = 1'b0;
   endfunction

   function automatic void m_fail(input bit ovf);
      m_err = 1'b1;
      m_ovf = ovf;
   endfunction

   function automatic void model_step(input logic [2:0] c, input logic [15:0] pd, input logic [15:0] s);
      int n;
      logic [15:0] t;
      n = m_stk.size();
      if (c == CMD_CLR) begin
         m_reset();
      end else if (!m_err) begin
         case (c)
            CMD_PUSH:  if (n == DEPTH) m_fail(1'b1); else m_stk.push_back(pd);
            CMD_POP:   if (n < 1) m_fail(1'b0); else void'(m_stk.pop_back());
            CMD_BINOP: if (n < 2) m_fail(1'b0);
                       else begin
                          void'(m_stk.pop_back());
                          void'(m_stk.pop_back());
                          m_stk.push_back(s);
                       end
            CMD_UNOP:  if (n < 1) m_fail(1'b0); else m_stk[n-1] = s;
            CMD_DUP:   if (n < 1) m_fail(1'b0);
                       else if (n == DEPTH) m_fail(1'b1);
                       else m_stk.push_back(m_stk[n-1]);
            CMD_SWAP:  if (n < 2) m_fail(1'b0);
                       else begin
                          t          = m_stk[n-1];
                          m_stk[n-1] = m_stk[n-2];
                          m_stk[n-2] = t;
                       end
            default: ;
         endcase
      end
   endfunction

   function automatic exp_t model_view(input string nm);
      exp_t e;
      e.tos   = m_tos();
      e.nos   = m_nos();
      e.count = 5'(m_stk.size());
      e.empty = (m_stk.size() == 0);
      e.full  = (m_stk.size() == DEPTH);
      e.err   = m_err;
      e.ovf   = m_ovf;
      e.name  = nm;
      return e;
   endfunction

   // Issue one command on the next edge and queue the model's expectation.
   task automatic do_cmd(input logic [2:0] c, input logic [15:0] pd, input string nm);
      logic [15:0] s;
      @(negedge clk);
      bus.cmd       = c;
      bus.push_data = pd;
      s = alu_fn(alu_op, m_tos(), m_nos());
      @(posedge clk);
      #1;
      model_step(c, pd, s);
      sb.push_back(model_view(nm));
      bus.cmd = CMD_NOP;
   endtask

   // Direct check against hand-derived constants.
   task automatic check_now(input string nm, input logic [15:0] tos, input logic [15:0] nos,
                            input logic [4:0] cnt, input logic err, input logic ovf);
      checks++;
      if (bus.tos !== tos || bus.nos !== nos || bus.count !== cnt ||
          bus.err !== err || bus.err_ovf !== ovf) begin
         errors++;
         $display("FAIL %s: got tos=%h nos=%h cnt=%0d err=%b ovf=%b, want tos=%h nos=%h cnt=%0d err=%b ovf=%b",
                  nm, bus.tos, bus.nos, bus.count, bus.err, bus.err_ovf, tos, nos, cnt, err, ovf);
      end
   endtask

   // Scoreboard monitor: outputs are stable by the falling edge.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         checks++;
         if (bus.tos !== e.tos || bus.nos !== e.nos || bus.count !== e.count ||
             bus.empty !== e.empty || bus.full !== e.full ||
             bus.err !== e.err || bus.err_ovf !== e.ovf) begin
            errors++;
            $display("FAIL %s: got tos=%h nos=%h cnt=%0d e=%b f=%b err=%b ovf=%b, want tos=%h nos=%h cnt=%0d e=%b f=%b err=%b ovf=%b",
                     e.name, bus.tos, bus.nos, bus.count, bus.empty, bus.full, bus.err, bus.err_ovf,
                     e.tos, e.nos, e.count, e.empty, e.full, e.err, e.ovf);
         end
      end
   end

   initial begin
      int r;
      logic [2:0] c;
      rst           = 1'b1;
      alu_op        = ALU_ADD;
      bus.cmd       = CMD_NOP;
      bus.push_data = '0;
      m_reset();
      @(negedge clk);
      check_now("reset", 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
      rst = 1'b0;

      // PUSH/PUSH/BINOP with SUB
      alu_op = ALU_SUB;
      do_cmd(CMD_PUSH, 16'd5, "push5");
      do_cmd(CMD_PUSH, 16'd3, "push3");
      check_now("push_pair", 16'd3, 16'd5, 5'd2, 1'b0, 1'b0);
      do_cmd(CMD_BINOP, 16'h0, "binop_sub");
      check_now("binop_sub", 16'h0002, 16'h0, 5'd1, 1'b0, 1'b0);
      do_cmd(CMD_CLR, 16'h0, "clr1");

      // Regfile refill path
      for (int i = 1; i <= 4; i++) do_cmd(CMD_PUSH, 16'(i), "push_seq");
      do_cmd(CMD_POP, 16'h0, "pop1");
      check_now("pop1", 16'd3, 16'd2, 5'd3, 1'b0, 1'b0);
      do_cmd(CMD_POP, 16'h0, "pop2");
      check_now("pop2", 16'd2, 16'd1, 5'd2, 1'b0, 1'b0);
      do_cmd(CMD_POP, 16'h0, "pop3");
      check_now("pop3", 16'd1, 16'd0, 5'd1, 1'b0, 1'b0);
      do_cmd(CMD_POP, 16'h0, "pop_to_empty");
      check_now("pop_to_empty", 16'd0, 16'd0, 5'd0, 1'b0, 1'b0);

      // Fill and overflow
      for (int i = 0; i < DEPTH; i++) do_cmd(CMD_PUSH, 16'(i), "fill");
      check_now("full", 16'd15, 16'd14, 5'd16, 1'b0, 1'b0);
      do_cmd(CMD_PUSH, 16'h0099, "overflow");
      check_now("overflow", 16'd15, 16'd14, 5'd16, 1'b1, 1'b1);
      do_cmd(CMD_POP, 16'h0, "pop_in_err");
      check_now("pop_in_err", 16'd15, 16'd14, 5'd16, 1'b1, 1'b1);
      do_cmd(CMD_CLR, 16'h0, "clr_ovf");
      check_now("clr_ovf", 16'd0, 16'd0, 5'd0, 1'b0, 1'b0);

      // Underflow
      do_cmd(CMD_PUSH, 16'd7, "push7");
      do_cmd(CMD_BINOP, 16'h0, "binop_uflow");
      check_now("binop_uflow", 16'd7, 16'd0, 5'd1, 1'b1, 1'b0);
      do_cmd(CMD_SWAP, 16'h0, "swap_in_err");
      check_now("swap_in_err", 16'd7, 16'd0, 5'd1, 1'b1, 1'b0);
      do_cmd(CMD_CLR, 16'h0, "clr_uflow");

      // UNOP / DUP / SWAP
      alu_op = ALU_BNOT;
      do_cmd(CMD_PUSH, 16'h00F0, "push_f0");
      do_cmd(CMD_UNOP, 16'h0, "unop_bnot");
      check_now("unop_bnot", 16'hFF0F, 16'h0, 5'd1, 1'b0, 1'b0);
      do_cmd(CMD_DUP, 16'h0, "dup");
      check_now("dup", 16'hFF0F, 16'hFF0F, 5'd2, 1'b0, 1'b0);
      do_cmd(CMD_SWAP, 16'h0, "swap_eq");
      check_now("swap_eq", 16'hFF0F, 16'hFF0F, 5'd2, 1'b0, 1'b0);
      do_cmd(CMD_CLR, 16'h0, "clr_dup");

      // Asynchronous reset between edges during a PUSH burst at count 6
      for (int i = 0; i < 6; i++) do_cmd(CMD_PUSH, 16'(16'h100 + i), "burst");
      @(negedge clk);
      bus.cmd       = CMD_PUSH;
      bus.push_data = 16'h0777;
      #2;
      rst = 1'b1;
      sb.delete();
      m_reset();
      #1;
      check_now("async_rst", 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst     = 1'b0;
      bus.cmd = CMD_NOP;
      do_cmd(CMD_POP, 16'h0, "pop_after_rst");
      check_now("pop_after_rst", 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
      do_cmd(CMD_CLR, 16'h0, "clr_rst");

      // Randomized commands
      for (int k = 0; k < 400; k++) begin
         r = int'($urandom_range(0, 99));
         if      (r < 35) c = CMD_PUSH;
         else if (r < 50) c = CMD_POP;
         else if (r < 60) c = CMD_BINOP;
         else if (r < 68) c = CMD_UNOP;
         else if (r < 78) c = CMD_DUP;
         else if (r < 88) c = CMD_SWAP;
         else if (r < 95) c = CMD_NOP;
         else             c = CMD_CLR;
         alu_op = int'($urandom_range(0, 3));
         do_cmd(c, 16'($urandom), "random");
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
